commit_unit: RTL and testbench

Parametrised in-order retirement stage for the out-of-order backend; the successor to the fixed two-wide commit stage. It sits between the ROB head and the rename map / frontend / store buffer. Each cycle it retires up to COMMIT_WIDTH completed micro-ops in order, tracks MIPS branch delay slots across cycle boundaries, raises precise exceptions, and issues registered flush/redirect, rename-commit, store-fire and predictor-update outputs.

---
 rtl/commit_unit_if.sv | 38 +++
 rtl/commit_unit.sv | 190 +++++++++++++++++++
 tb/tb_commit_unit.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/commit_unit_if.sv
// ROB head bundle presented to the commit stage. The ROB drives the head
// slot fields and the commit stage answers with the combinational pop mask.
interface commit_unit_if #(
  parameter int W     = 2,
  parameter int PRF_W = 6
);
  logic [W-1:0]            rob_valid;
  logic [W-1:0]            rob_busy;
  logic [W-1:0][31:0]      rob_pc;
  logic [W-1:0][31:0]      rob_br_addr;
  logic [W-1:0][31:0]      rob_pred_addr;
  logic [W-1:0]            rob_is_br;
  logic [W-1:0]            rob_br_taken;
  logic [W-1:0]            rob_pred_taken;
  logic [W-1:0]            rob_in_ds;
  logic [W-1:0]            rob_is_store;
  logic [W-1:0]            rob_exc;
  logic [W-1:0][4:0]       rob_exc_code;
  logic [W-1:0]            rob_dst_we;
  logic [W-1:0][4:0]       rob_dst_arf;
  logic [W-1:0][PRF_W-1:0] rob_dst_prf;
  logic [W-1:0][PRF_W-1:0] rob_stale_prf;
  logic [W-1:0]            rob_retire;

  modport master (
    output rob_valid, rob_busy, rob_pc, rob_br_addr, rob_pred_addr, rob_is_br,
           rob_br_taken, rob_pred_taken, rob_in_ds, rob_is_store, rob_exc,
           rob_exc_code, rob_dst_we, rob_dst_arf, rob_dst_prf, rob_stale_prf,
    input  rob_retire
  );

  modport slave (
    input  rob_valid, rob_busy, rob_pc, rob_br_addr, rob_pred_addr, rob_is_br,
           rob_br_taken, rob_pred_taken, rob_in_ds, rob_is_store, rob_exc,
           rob_exc_code, rob_dst_we, rob_dst_arf, rob_dst_prf, rob_stale_prf,
    output rob_retire
  );
endinterface

// File: rtl/commit_unit.sv
// In-order commit stage: retires up to COMMIT_WIDTH head slots per cycle,
// carries a pending branch redirect across a cycle boundary while the delay
// slot is still in flight, and takes precise exceptions.
//
// state   | meaning
// RUN     | scan all head slots, retire the good prefix
// WAIT_DS | mispredicted branch retired, waiting for its delay slot in slot 0
// FLUSH   | one-cycle bubble after a redirect while the ROB clears
module commit_unit #(
  parameter int          COMMIT_WIDTH = 2,
  parameter int          PRF_W        = 6,
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               stall_i,
  commit_unit_if.slave                       rob,
  output logic [COMMIT_WIDTH-1:0]            commit_valid_o,
  output logic [COMMIT_WIDTH-1:0]            commit_we_o,
  output logic [COMMIT_WIDTH-1:0][4:0]       commit_arf_o,
  output logic [COMMIT_WIDTH-1:0][PRF_W-1:0] commit_prf_o,
  output logic [COMMIT_WIDTH-1:0][PRF_W-1:0] commit_stale_o,
  output logic [COMMIT_WIDTH-1:0]            store_fire_o,
  output logic                               redirect_valid_o,
  output logic [31:0]                        redirect_pc_o,
  output logic                               flush_req_o,
  output logic                               exc_valid_o,
  output logic [4:0]                         exc_code_o,
  output logic [31:0]                        exc_epc_o,
  output logic                               exc_bd_o,
  output logic                               bpu_upd_valid_o,
  output logic [31:0]                        bpu_upd_pc_o,
  output logic [31:0]                        bpu_upd_target_o,
  output logic                               bpu_upd_taken_o
);
  localparam int W = COMMIT_WIDTH;

  typedef enum logic [1:0] {S_RUN, S_WAIT_DS, S_FLUSH} state_e;

  state_e         state_q, state_d;
  logic [31:0]    tgt_q, tgt_d;
  logic [W-1:0]   good, mispred, retire_d;
  logic           redir_d;
  logic [31:0]    redir_pc_d;
  logic           exc_hit, stop, bpu_hit;
  int             exc_idx, nxt, bpu_idx;

  function automatic logic [31:0] br_target(logic taken, logic [31:0] addr, logic [31:0] pc);
    return taken ? addr : pc + 32'd8;
  endfunction

  // Per-slot readiness and branch misprediction detection
  always_comb begin
    good = rob.rob_valid & ~rob.rob_busy;
    for (int i = 0; i < W; i++) begin
      mispred[i] = rob.rob_is_br[i] &
                   ((rob.rob_br_taken[i] != rob.rob_pred_taken[i]) |
                    (rob.rob_br_taken[i] & (rob.rob_br_addr[i] != rob.rob_pred_addr[i])));
    end
  end

  // Retirement scan, redirect selection and next state
  always_comb begin
    retire_d   = '0;
    state_d    = state_q;
    tgt_d      = tgt_q;
    redir_d    = 1'b0;
    redir_pc_d = '0;
    exc_hit    = 1'b0;
    exc_idx    = 0;
    stop       = 1'b0;
    nxt        = 0;
    if (state_q == S_FLUSH) begin
      state_d = S_RUN;
    end else if (rst_n && !stall_i) begin
      if (state_q == S_WAIT_DS) begin
        if (good[0]) begin
          if (rob.rob_exc[0]) begin
            exc_hit = 1'b1;
          end else begin
            retire_d[0] = 1'b1;
            redir_d     = 1'b1;
            redir_pc_d  = tgt_q;
            tgt_d       = '0;
            state_d     = S_FLUSH;
          end
        end
      end else begin
        for (int i = 0; i < W; i++) begin
          nxt = (i < W - 1) ? i + 1 : i;
          if (!stop) begin
            if (!good[i]) begin
              stop = 1'b1;
            end else if (rob.rob_exc[i]) begin
              stop    = 1'b1;
              exc_hit = 1'b1;
              exc_idx = i;
            end else begin
              retire_d[i] = 1'b1;
              if (mispred[i]) begin
                stop = 1'b1;
                // Delay slot already in the window: resolve the whole pair now
                if ((i < W - 1) && good[nxt]) begin
                  if (rob.rob_exc[nxt]) begin
                    exc_hit = 1'b1;
                    exc_idx = nxt;
                  end else begin
                    retire_d[nxt] = 1'b1;
                    redir_d       = 1'b1;
                    redir_pc_d    = br_target(rob.rob_br_taken[i], rob.rob_br_addr[i], rob.rob_pc[i]);
                    state_d       = S_FLUSH;
                  end
                end else begin
                  tgt_d   = br_target(rob.rob_br_taken[i], rob.rob_br_addr[i], rob.rob_pc[i]);
                  state_d = S_WAIT_DS;
                end
              end
            end
          end
        end
      end
      if (exc_hit) begin
        redir_d    = 1'b1;
        redir_pc_d = EXC_VECTOR;
        tgt_d      = '0;
        state_d    = S_FLUSH;
      end
    end
  end

  // Oldest retired branch feeds the predictor update
  always_comb begin
    bpu_hit = 1'b0;
    bpu_idx = 0;
    for (int i = 0; i < W; i++) begin
      if (!bpu_hit && retire_d[i] && rob.rob_is_br[i]) begin
        bpu_hit = 1'b1;
        bpu_idx = i;
      end
    end
  end

  assign rob.rob_retire = retire_d;

  // FSM state, latched branch target and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_RUN;
      tgt_q            <= '0;
      commit_valid_o   <= '0;
      commit_we_o      <= '0;
      commit_arf_o     <= '0;
      commit_prf_o     <= '0;
      commit_stale_o   <= '0;
      store_fire_o     <= '0;
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= '0;
      flush_req_o      <= 1'b0;
      exc_valid_o      <= 1'b0;
      exc_code_o       <= '0;
      exc_epc_o        <= '0;
      exc_bd_o         <= 1'b0;
      bpu_upd_valid_o  <= 1'b0;
      bpu_upd_pc_o     <= '0;
      bpu_upd_target_o <= '0;
      bpu_upd_taken_o  <= 1'b0;
    end else begin
      state_q          <= state_d;
      tgt_q            <= tgt_d;
      commit_valid_o   <= retire_d;
      commit_we_o      <= retire_d & rob.rob_dst_we;
      commit_arf_o     <= rob.rob_dst_arf;
      commit_prf_o     <= rob.rob_dst_prf;
      commit_stale_o   <= rob.rob_stale_prf;
      store_fire_o     <= retire_d & rob.rob_is_store;
      redirect_valid_o <= redir_d;
      redirect_pc_o    <= redir_pc_d;
      flush_req_o      <= redir_d;
      exc_valid_o      <= exc_hit;
      exc_code_o       <= exc_hit ? rob.rob_exc_code[exc_idx] : 5'd0;
      exc_epc_o        <= !exc_hit ? 32'd0 :
                          rob.rob_in_ds[exc_idx] ? rob.rob_pc[exc_idx] - 32'd4 : rob.rob_pc[exc_idx];
      exc_bd_o         <= exc_hit & rob.rob_in_ds[exc_idx];
      bpu_upd_valid_o  <= bpu_hit;
      bpu_upd_pc_o     <= bpu_hit ? rob.rob_pc[bpu_idx] : 32'd0;
      bpu_upd_target_o <= bpu_hit ? rob.rob_br_addr[bpu_idx] : 32'd0;
      bpu_upd_taken_o  <= bpu_hit & rob.rob_br_taken[bpu_idx];
    end
  end
endmodule

// File: tb/tb_commit_unit.sv
// Bench for commit_unit: a table of single-cycle retirement cases on a
// two-wide instance, plus hand-written delay-slot, stall/reset and four-wide
// exception sequences.
module tb_commit_unit;
  localparam logic [31:0] EXC_VEC = 32'hBFC0_0380;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stall = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  commit_unit_if #(.W(2), .PRF_W(6)) if2 ();
  commit_unit_if #(.W(4), .PRF_W(6)) if4 ();

  logic [1:0]      c2_valid, c2_we, c2_store;
  logic [1:0][4:0] c2_arf;
  logic [1:0][5:0] c2_prf, c2_stale;
  logic            r2_valid, r2_flush, e2_valid, e2_bd, b2_valid, b2_taken;
  logic [31:0]     r2_pc, e2_epc, b2_pc, b2_tgt;
  logic [4:0]      e2_code;

  logic [3:0]      c4_valid, c4_we, c4_store;
  logic [3:0][4:0] c4_arf;
  logic [3:0][5:0] c4_prf, c4_stale;
  logic            r4_valid, r4_flush, e4_valid, e4_bd, b4_valid, b4_taken;
  logic [31:0]     r4_pc, e4_epc, b4_pc, b4_tgt;
  logic [4:0]      e4_code;

  commit_unit #(.COMMIT_WIDTH(2), .PRF_W(6), .EXC_VECTOR(EXC_VEC)) u2 (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .rob(if2),
    .commit_valid_o(c2_valid), .commit_we_o(c2_we), .commit_arf_o(c2_arf),
    .commit_prf_o(c2_prf), .commit_stale_o(c2_stale), .store_fire_o(c2_store),
    .redirect_valid_o(r2_valid), .redirect_pc_o(r2_pc), .flush_req_o(r2_flush),
    .exc_valid_o(e2_valid), .exc_code_o(e2_code), .exc_epc_o(e2_epc), .exc_bd_o(e2_bd),
    .bpu_upd_valid_o(b2_valid), .bpu_upd_pc_o(b2_pc), .bpu_upd_target_o(b2_tgt),
    .bpu_upd_taken_o(b2_taken)
  );

  commit_unit #(.COMMIT_WIDTH(4), .PRF_W(6), .EXC_VECTOR(EXC_VEC)) u4 (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .rob(if4),
    .commit_valid_o(c4_valid), .commit_we_o(c4_we), .commit_arf_o(c4_arf),
    .commit_prf_o(c4_prf), .commit_stale_o(c4_stale), .store_fire_o(c4_store),
    .redirect_valid_o(r4_valid), .redirect_pc_o(r4_pc), .flush_req_o(r4_flush),
    .exc_valid_o(e4_valid), .exc_code_o(e4_code), .exc_epc_o(e4_epc), .exc_bd_o(e4_bd),
    .bpu_upd_valid_o(b4_valid), .bpu_upd_pc_o(b4_pc), .bpu_upd_target_o(b4_tgt),
    .bpu_upd_taken_o(b4_taken)
  );

  typedef struct {
    string       nm;
    logic [1:0]  valid, busy, is_br, taken, ptaken, in_ds, exc, store;
    logic [31:0] pc0, pc1, br0, pa0;
    logic [1:0]  e_retire, e_store;
    logic        e_redir;
    logic [31:0] e_rpc;
    logic        e_exc;
    logic [31:0] e_epc;
    logic        e_bd, e_bpu;
    logic [31:0] e_bpu_pc, e_bpu_tgt;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic clr2();
    if2.rob_valid = '0; if2.rob_busy = '0; if2.rob_pc = '0;
    if2.rob_br_addr = {32'h900, 32'h0}; if2.rob_pred_addr = {32'h900, 32'h0};
    if2.rob_is_br = '0; if2.rob_br_taken = '0; if2.rob_pred_taken = '0;
    if2.rob_in_ds = '0; if2.rob_is_store = '0; if2.rob_exc = '0;
    if2.rob_exc_code = {5'd8, 5'd8}; if2.rob_dst_we = 2'b11;
    if2.rob_dst_arf = {5'd4, 5'd3}; if2.rob_dst_prf = {6'd11, 6'd10};
    if2.rob_stale_prf = {6'd21, 6'd20};
  endtask

  task automatic clr4();
    if4.rob_valid = '0; if4.rob_busy = '0; if4.rob_pc = '0;
    if4.rob_br_addr = '0; if4.rob_pred_addr = '0;
    if4.rob_is_br = '0; if4.rob_br_taken = '0; if4.rob_pred_taken = '0;
    if4.rob_in_ds = '0; if4.rob_is_store = '0; if4.rob_exc = '0;
    if4.rob_exc_code = '0; if4.rob_dst_we = '0; if4.rob_dst_arf = '0;
    if4.rob_dst_prf = '0; if4.rob_stale_prf = '0;
  endtask

  initial begin
    //          nm            valid  busy   is_br  taken  ptaken in_ds  exc    store  pc0        pc1        br0        pa0        ret    st     rd    rpc           ex    epc        bd    bpu   bpu_pc     bpu_tgt
    vecs[0]  = '{"alu2",      2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 32'h100,  32'h104,  32'h0,    32'h0,    2'b11, 2'b00, 1'b0, 32'h0,        1'b0, 32'h0,    1'b0, 1'b0, 32'h0,    32'h0};
    vecs[1]  = '{"s0busy",    2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 32'h100,  32'h104,  32'h0,    32'h0,    2'b00, 2'b00, 1'b0, 32'h0,        1'b0, 32'h0,    1'b0, 1'b0, 32'h0,    32'h0};
    vecs[2]  = '{"s1busy",    2'b11, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 32'h100,  32'h104,  32'h0,    32'h0,    2'b01, 2'b00, 1'b0, 32'h0,        1'b0, 32'h0,    1'b0, 1'b0, 32'h0,    32'h0};
    vecs[3]  = '{"exc0",      2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 32'h100,  32'h104,  32'h0,    32'h0,    2'b00, 2'b00, 1'b1, EXC_VEC,      1'b1, 32'h100,  1'b0, 1'b0, 32'h0,    32'h0};
    vecs[4]  = '{"exc1ds",    2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 32'h100,  32'h104,  32'h0,    32'h0,    2'b01, 2'b00, 1'b1, EXC_VEC,      1'b1, 32'h100,  1'b1, 1'b0, 32'h0,    32'h0};
    vecs[5]  = '{"mp_addr",   2'b11, 2'b00, 2'b01, 2'b01, 2'b01, 2'b10, 2'b00, 2'b00, 32'h100,  32'h104,  32'h600,  32'h500,  2'b11, 2'b00, 1'b1, 32'h600,      1'b0, 32'h0,    1'b0, 1'b1, 32'h100,  32'h600};
    vecs[6]  = '{"mp_dsexc",  2'b11, 2'b00, 2'b01, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 32'h2000, 32'h2004, 32'h3000, 32'h3000, 2'b01, 2'b00, 1'b1, EXC_VEC,      1'b1, 32'h2000, 1'b1, 1'b1, 32'h2000, 32'h3000};
    vecs[7]  = '{"two_br",    2'b11, 2'b00, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 32'h100,  32'h104,  32'h700,  32'h700,  2'b11, 2'b00, 1'b0, 32'h0,        1'b0, 32'h0,    1'b0, 1'b1, 32'h100,  32'h700};
    vecs[8]  = '{"stores",    2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 32'h100,  32'h104,  32'h0,    32'h0,    2'b11, 2'b11, 1'b0, 32'h0,        1'b0, 32'h0,    1'b0, 1'b0, 32'h0,    32'h0};
    vecs[9]  = '{"nt_ok",     2'b11, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 32'h100,  32'h104,  32'h700,  32'h900,  2'b11, 2'b00, 1'b0, 32'h0,        1'b0, 32'h0,    1'b0, 1'b1, 32'h100,  32'h700};
    vecs[10] = '{"mp_nt2t",   2'b11, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 32'h100,  32'h104,  32'h800,  32'h0,    2'b11, 2'b00, 1'b1, 32'h800,      1'b0, 32'h0,    1'b0, 1'b1, 32'h100,  32'h800};
    vecs[11] = '{"mp_t2nt",   2'b11, 2'b00, 2'b01, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 32'h100,  32'h104,  32'h800,  32'h800,  2'b11, 2'b00, 1'b1, 32'h108,      1'b0, 32'h0,    1'b0, 1'b1, 32'h100,  32'h800};
    vecs[12] = '{"empty",     2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 32'h100,  32'h104,  32'h0,    32'h0,    2'b00, 2'b00, 1'b0, 32'h0,        1'b0, 32'h0,    1'b0, 1'b0, 32'h0,    32'h0};
    vecs[13] = '{"st_hole",   2'b11, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 32'h100,  32'h104,  32'h0,    32'h0,    2'b01, 2'b01, 1'b0, 32'h0,        1'b0, 32'h0,    1'b0, 1'b0, 32'h0,    32'h0};

    clr2();
    clr4();
    // Good slots offered while in reset must not be popped
    if2.rob_valid = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_retire2", 32'(if2.rob_retire), 32'h0);
    chk("rst_cvalid2", 32'(c2_valid), 32'h0);
    chk("rst_redir2", 32'(r2_valid), 32'h0);
    chk("rst_flush2", 32'(r2_flush), 32'h0);
    chk("rst_exc2", 32'(e2_valid), 32'h0);
    chk("rst_bpu2", 32'(b2_valid), 32'h0);
    chk("rst_cvalid4", 32'(c4_valid), 32'h0);
    chk("rst_redir4", 32'(r4_valid), 32'h0);
    rst_n = 1'b1;
    clr2();
    @(negedge clk);

    // Rename data echo for two plain ALU ops
    if2.rob_valid = 2'b11;
    #1;
    chk("echo_retire", 32'(if2.rob_retire), 32'h3);
    @(posedge clk); #1;
    chk("echo_cvalid", 32'(c2_valid), 32'h3);
    chk("echo_we", 32'(c2_we), 32'h3);
    chk("echo_arf", 32'(c2_arf), 32'h083);
    chk("echo_prf", 32'(c2_prf), 32'h2CA);
    chk("echo_stale", 32'(c2_stale), 32'h554);
    chk("echo_redir", 32'(r2_valid), 32'h0);
    clr2();

    // Table of single-cycle cases, each started from RUN
    for (int v = 0; v < 14; v++) begin
      @(negedge clk);
      if2.rob_valid = vecs[v].valid; if2.rob_busy = vecs[v].busy;
      if2.rob_is_br = vecs[v].is_br; if2.rob_br_taken = vecs[v].taken;
      if2.rob_pred_taken = vecs[v].ptaken; if2.rob_in_ds = vecs[v].in_ds;
      if2.rob_exc = vecs[v].exc; if2.rob_is_store = vecs[v].store;
      if2.rob_pc = {vecs[v].pc1, vecs[v].pc0};
      if2.rob_br_addr = {32'h900, vecs[v].br0};
      if2.rob_pred_addr = {32'h900, vecs[v].pa0};
      #1;
      chk({vecs[v].nm, "_retire"}, 32'(if2.rob_retire), 32'(vecs[v].e_retire));
      @(posedge clk); #1;
      chk({vecs[v].nm, "_cvalid"}, 32'(c2_valid), 32'(vecs[v].e_retire));
      chk({vecs[v].nm, "_store"}, 32'(c2_store), 32'(vecs[v].e_store));
      chk({vecs[v].nm, "_redir"}, 32'(r2_valid), 32'(vecs[v].e_redir));
      chk({vecs[v].nm, "_flush"}, 32'(r2_flush), 32'(vecs[v].e_redir));
      if (vecs[v].e_redir) chk({vecs[v].nm, "_rpc"}, r2_pc, vecs[v].e_rpc);
      chk({vecs[v].nm, "_exc"}, 32'(e2_valid), 32'(vecs[v].e_exc));
      if (vecs[v].e_exc) begin
        chk({vecs[v].nm, "_code"}, 32'(e2_code), 32'd8);
        chk({vecs[v].nm, "_epc"}, e2_epc, vecs[v].e_epc);
        chk({vecs[v].nm, "_bd"}, 32'(e2_bd), 32'(vecs[v].e_bd));
      end
      chk({vecs[v].nm, "_bpu"}, 32'(b2_valid), 32'(vecs[v].e_bpu));
      if (vecs[v].e_bpu) begin
        chk({vecs[v].nm, "_bpu_pc"}, b2_pc, vecs[v].e_bpu_pc);
        chk({vecs[v].nm, "_bpu_tgt"}, b2_tgt, vecs[v].e_bpu_tgt);
      end
      clr2();
      repeat (2) @(posedge clk);
    end

    // Mispredicted branch in the last slot: wait for its delay slot
    @(negedge clk);
    if2.rob_valid = 2'b11; if2.rob_pc = {32'h104, 32'h100};
    if2.rob_is_br = 2'b10; if2.rob_br_taken = 2'b10; if2.rob_pred_taken = 2'b00;
    if2.rob_br_addr = {32'h8000_0100, 32'h0};
    #1;
    chk("wds_enter_retire", 32'(if2.rob_retire), 32'h3);
    @(posedge clk); #1;
    chk("wds_enter_redir", 32'(r2_valid), 32'h0);
    chk("wds_bpu_pc", b2_pc, 32'h104);
    clr2();
    if2.rob_valid = 2'b11; if2.rob_busy = 2'b01; if2.rob_pc = {32'h10C, 32'h108};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("wds_busy_retire", 32'(if2.rob_retire), 32'h0);
    end
    @(negedge clk);
    if2.rob_busy = 2'b00;
    #1;
    chk("wds_ds_retire", 32'(if2.rob_retire), 32'h1);
    @(posedge clk); #1;
    chk("wds_redir", 32'(r2_valid), 32'h1);
    chk("wds_flush", 32'(r2_flush), 32'h1);
    chk("wds_rpc", r2_pc, 32'h8000_0100);
    chk("wds_cvalid", 32'(c2_valid), 32'h1);
    chk("flush_retire", 32'(if2.rob_retire), 32'h0);
    @(posedge clk); #1;
    chk("flush_redir_off", 32'(r2_valid), 32'h0);
    chk("flush_cvalid", 32'(c2_valid), 32'h0);
    chk("run_again_retire", 32'(if2.rob_retire), 32'h3);
    @(negedge clk);
    clr2();
    repeat (2) @(posedge clk);

    // Four-wide: store, ALU, then a faulting op
    @(negedge clk);
    if4.rob_valid = 4'b1111; if4.rob_is_store = 4'b0001; if4.rob_exc = 4'b0100;
    if4.rob_exc_code[2] = 5'd4; if4.rob_pc[2] = 32'h1000;
    #1;
    chk("w4_retire", 32'(if4.rob_retire), 32'h3);
    @(posedge clk); #1;
    chk("w4_store", 32'(c4_store), 32'h1);
    chk("w4_cvalid", 32'(c4_valid), 32'h3);
    chk("w4_exc", 32'(e4_valid), 32'h1);
    chk("w4_code", 32'(e4_code), 32'd4);
    chk("w4_epc", e4_epc, 32'h1000);
    chk("w4_bd", 32'(e4_bd), 32'h0);
    chk("w4_rpc", r4_pc, EXC_VEC);
    chk("w4_flush", 32'(r4_flush), 32'h1);
    clr4();

    // Stall held in WAIT_DS, then reset drops the pending redirect
    @(negedge clk);
    if2.rob_valid = 2'b01; if2.rob_pc = {32'h0, 32'h200};
    if2.rob_is_br = 2'b01; if2.rob_br_taken = 2'b01; if2.rob_br_addr = {32'h900, 32'h4000};
    #1;
    chk("sr_enter_retire", 32'(if2.rob_retire), 32'h1);
    @(posedge clk);
    @(negedge clk);
    clr2();
    stall = 1'b1;
    if2.rob_valid = 2'b01; if2.rob_pc = {32'h0, 32'h208};
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("sr_stall_retire", 32'(if2.rob_retire), 32'h0);
      @(negedge clk);
    end
    rst_n = 1'b0;
    stall = 1'b0;
    #1;
    chk("sr_rst_retire", 32'(if2.rob_retire), 32'h0);
    chk("sr_rst_cvalid", 32'(c2_valid), 32'h0);
    chk("sr_rst_redir", 32'(r2_valid), 32'h0);
    chk("sr_rst_bpu", 32'(b2_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("sr_post_retire", 32'(if2.rob_retire), 32'h1);
    @(posedge clk); #1;
    chk("sr_post_cvalid", 32'(c2_valid), 32'h1);
    chk("sr_post_redir", 32'(r2_valid), 32'h0);
    chk("sr_post_flush", 32'(r2_flush), 32'h0);
    clr2();
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
